// File: rtl/fetch_controller_if.sv
// Bus bundle between the fetch controller, instruction memory and stage 2.
// The master side is the fetch controller itself.
interface fetch_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  jmp;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  stall;
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ready;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic [DATA_WIDTH-1:0] inst_out;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  inst_valid;

    modport master (
        input  jmp, offset, stall, imem_ready, imem_rdata,
        output imem_req, imem_addr, pc_out, inst_out, inst_pc, inst_valid
    );

    modport slave (
        output jmp, offset, stall, imem_ready, imem_rdata,
        input  imem_req, imem_addr, pc_out, inst_out, inst_pc, inst_valid
    );
endinterface

// File: rtl/fetch_controller.sv
// Stage-1 fetch sequencer: PC register, single-outstanding instruction memory
// requests and a one-entry output register toward stage 2 with jump flushing.
module fetch_controller #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    PC_STEP    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic                  req;
    logic                  load;
    logic                  redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_pc_q <= '0;
            inst_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_pc_q <= inst_pc_d;
            inst_q    <= inst_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        load     = 1'b0;
        redirect = bus.jmp && (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  state_d = S_ISSUE;
            S_ISSUE: begin
                // Issue only when the output slot will be free by the time data returns.
                if (!bus.jmp && (!valid_q || !bus.stall)) begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_ready) begin
                    load    = !bus.jmp;
                    state_d = S_ISSUE;
                end else if (bus.jmp) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.imem_ready) begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pc_d = pc_q;
        if (redirect) begin
            pc_d = pc_q + bus.offset;
        end else if (load) begin
            pc_d = pc_q + STEP;
        end

        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        if (load) begin
            inst_d    = bus.imem_rdata;
            inst_pc_d = pc_q;
        end

        // Flush beats reload beats consume.
        valid_d = valid_q;
        if (redirect) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && !bus.stall) begin
            valid_d = 1'b0;
        end
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc_q;
    assign bus.pc_out     = pc_q;
    assign bus.inst_out   = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = valid_q;
endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: two instances (reset PC 0x000 and 0xFFC) share stimulus
// and a latency-programmable memory; every cycle is compared against a transaction-level model.
module tb_fetch_controller;
    localparam int              AW   = 12;
    localparam int              DW   = 32;
    localparam logic [AW-1:0]   RPC1 = 12'hFFC;

    logic          clk = 1'b0;
    logic          rst;
    logic          jmp;
    logic [AW-1:0] offset;
    logic          stall;
    logic          ready;
    logic [DW-1:0] rdata [2];

    always #5 clk = ~clk;

    fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.jmp        = jmp;
    assign bus0.offset     = offset;
    assign bus0.stall      = stall;
    assign bus0.imem_ready = ready;
    assign bus0.imem_rdata = rdata[0];
    assign bus1.jmp        = jmp;
    assign bus1.offset     = offset;
    assign bus1.stall      = stall;
    assign bus1.imem_ready = ready;
    assign bus1.imem_rdata = rdata[1];

    fetch_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_STEP(4), .RESET_PC(12'h000)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    fetch_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_STEP(4), .RESET_PC(RPC1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit verbose  = 1'b1;

    // Transaction-level model: "just out of reset", "request in flight",
    // "in-flight response is stale", and the stage-2 slot contents per instance.
    bit            m_idle, m_busy, m_stale, m_valid;
    logic [AW-1:0] m_pc  [2];
    logic [AW-1:0] m_ipc [2];
    logic [DW-1:0] m_inst[2];

    // Memory: one pending response, returned mem_lat cycles after the request.
    bit            pend = 1'b0;
    int            cnt  = 0;
    int            mem_lat = 1;
    logic [AW-1:0] pend_addr[2];

    function automatic logic [DW-1:0] mem_word(int inst, logic [AW-1:0] a);
        return {4'(inst), 4'hE, a, ~a};
    endfunction

    function automatic bit exp_req();
        return (rst !== 1'b1) && !m_idle && !m_busy && !m_stale && !jmp && (!m_valid || !stall);
    endfunction

    function automatic logic [69:0] exp_vec(int i);
        return {exp_req(), m_pc[i], m_pc[i], m_valid, m_ipc[i], m_inst[i]};
    endfunction

    function automatic logic [69:0] obs_vec(int i);
        if (i == 0)
            return {bus0.imem_req, bus0.imem_addr, bus0.pc_out, bus0.inst_valid, bus0.inst_pc, bus0.inst_out};
        return {bus1.imem_req, bus1.imem_addr, bus1.pc_out, bus1.inst_valid, bus1.inst_pc, bus1.inst_out};
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_busy  = 1'b0;
        m_stale = 1'b0;
        m_valid = 1'b0;
        m_pc[0] = 12'h000;
        m_pc[1] = RPC1;
        for (int i = 0; i < 2; i++) begin
            m_ipc[i]  = '0;
            m_inst[i] = '0;
        end
    endtask

    // Advance model and memory across one rising edge, then drive memory outputs.
    task automatic tick();
        bit req, load;
        req = exp_req();
        if (req) begin
            pend      = 1'b1;
            cnt       = mem_lat;
            pend_addr = m_pc;
        end
        if (rst === 1'b1) begin
            model_reset();
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            load = m_busy && ready && !jmp;
            if (verbose && m_valid && !stall && !jmp)
                $display("consume pc=%h inst=%h | pc=%h inst=%h", m_ipc[0], m_inst[0], m_ipc[1], m_inst[1]);
            for (int i = 0; i < 2; i++) begin
                if (load) begin
                    m_inst[i] = rdata[i];
                    m_ipc[i]  = m_pc[i];
                end
                if (jmp)       m_pc[i] = m_pc[i] + offset;
                else if (load) m_pc[i] = m_pc[i] + 12'd4;
            end
            if (jmp)                    m_valid = 1'b0;
            else if (load)              m_valid = 1'b1;
            else if (m_valid && !stall) m_valid = 1'b0;
            if (req) begin
                m_busy = 1'b1;
            end else if (m_busy) begin
                if (ready) begin
                    m_busy = 1'b0;
                end else if (jmp) begin
                    m_busy  = 1'b0;
                    m_stale = 1'b1;
                end
            end else if (m_stale && ready) begin
                m_stale = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        ready = 1'b0;
        for (int i = 0; i < 2; i++) rdata[i] = $urandom;
        if (pend) begin
            cnt--;
            if (cnt <= 0) begin
                ready = 1'b1;
                pend  = 1'b0;
                for (int i = 0; i < 2; i++) rdata[i] = mem_word(i, pend_addr[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; jmp = 1'b0; stall = 1'b0; offset = '0; ready = 1'b0;
        rdata[0] = '0; rdata[1] = '0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i))
                $display("FAIL reset dut%0d t=%0t got=%h want=%h", i, $time, obs_vec(i), exp_vec(i));
            else n_pass++;
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        mem_lat = 1; jmp = 1'b0; stall = 1'b0;
        repeat (14) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i))
                    $display("FAIL sequential dut%0d t=%0t got=%h want=%h", i, $time, obs_vec(i), exp_vec(i));
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int c;
        mem_lat = 1; jmp = 1'b0;
        for (c = 0; c < 16; c++) begin
            stall = (c >= 3 && c < 6) ? 1'b1 : 1'b0;
            if (c == 2 && !m_valid) c = 1;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i))
                    $display("FAIL stall dut%0d t=%0t stall=%0b got=%h want=%h", i, $time, stall, obs_vec(i), exp_vec(i));
                else n_pass++;
            end
            tick();
        end
        stall = 1'b0;
    endtask

    task automatic test_jump_wait();
        bit done = 1'b0;
        mem_lat = 2; stall = 1'b0; offset = 12'h010;
        for (int c = 0; c < 16; c++) begin
            jmp = !done && m_busy && !ready;
            if (jmp) done = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i))
                    $display("FAIL jump_wait dut%0d t=%0t jmp=%0b got=%h want=%h", i, $time, jmp, obs_vec(i), exp_vec(i));
                else n_pass++;
            end
            tick();
        end
        jmp = 1'b0;
        n_checks++;
        if (!done) $display("FAIL jump_wait_timeout got=no_wait_cycle want=wait_cycle");
        else n_pass++;
    endtask

    task automatic test_jump_ready();
        bit done = 1'b0;
        mem_lat = 1; stall = 1'b0; offset = 12'hFFC;
        for (int c = 0; c < 16; c++) begin
            jmp = !done && m_busy && ready && (c > 4);
            if (jmp) done = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i))
                    $display("FAIL jump_ready dut%0d t=%0t jmp=%0b got=%h want=%h", i, $time, jmp, obs_vec(i), exp_vec(i));
                else n_pass++;
            end
            tick();
        end
        jmp = 1'b0;
        n_checks++;
        if (!done) $display("FAIL jump_ready_timeout got=no_ready_cycle want=ready_cycle");
        else n_pass++;
    endtask

    task automatic test_random();
        verbose = 1'b0;
        repeat (2000) begin
            jmp     = ($urandom_range(0, 7) == 0);
            offset  = ($urandom_range(0, 3) == 0) ? 12'hFFC : 12'($urandom);
            stall   = ($urandom_range(0, 2) == 0);
            mem_lat = $urandom_range(1, 3);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i))
                    $display("FAIL random dut%0d t=%0t jmp=%0b stall=%0b rdy=%0b got=%h want=%h",
                             i, $time, jmp, stall, ready, obs_vec(i), exp_vec(i));
                else n_pass++;
            end
            tick();
        end
        jmp = 1'b0; stall = 1'b0; verbose = 1'b1;
    endtask

    // Reset lands mid-WAIT; the old response arrives once the DUT is back in ISSUE.
    task automatic test_reset_mid_wait();
        bit hit = 1'b0;
        mem_lat = 3; jmp = 1'b0; stall = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i))
                    $display("FAIL rst_wait_pre dut%0d t=%0t got=%h want=%h", i, $time, obs_vec(i), exp_vec(i));
                else n_pass++;
            end
            tick();
            hit = m_busy && !ready;
        end
        n_checks++;
        if (!hit) $display("FAIL rst_wait_timeout got=no_wait want=wait");
        else n_pass++;
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 14; c++) begin
            if (c == 1) rst = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_vec(i) !== exp_vec(i))
                    $display("FAIL rst_wait dut%0d t=%0t rdy=%0b got=%h want=%h", i, $time, ready, obs_vec(i), exp_vec(i));
                else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump_wait();
        test_jump_ready();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
